// File: rtl/apb_fifo_pkg.sv
// Shared register map, STATUS layout and IRQ source encoding for apb_fifo_bridge.
package apb_fifo_pkg;

    // Word indices, selected by paddr[4:2]
    localparam logic [2:0] RegTxData = 3'd0;
    localparam logic [2:0] RegRxData = 3'd1;
    localparam logic [2:0] RegStatus = 3'd2;
    localparam logic [2:0] RegLevel  = 3'd3;
    localparam logic [2:0] RegCtrl   = 3'd4;
    localparam logic [2:0] RegNReads = 3'd5;
    localparam logic [2:0] RegThresh = 3'd6;
    localparam logic [2:0] RegIrq    = 3'd7;

    localparam int unsigned StTxEmpty = 0;
    localparam int unsigned StTxAe    = 1;
    localparam int unsigned StTxFull  = 2;
    localparam int unsigned StRxEmpty = 3;
    localparam int unsigned StRxAf    = 4;
    localparam int unsigned StRxFull  = 5;
    localparam int unsigned StEndRx   = 6;
    localparam int unsigned StTxOvf   = 7;
    localparam int unsigned StRxOvf   = 8;
    localparam int unsigned StRxUdf   = 9;

    typedef struct packed {
        logic rx_udf;
        logic rx_ovf;
        logic tx_ovf;
        logic end_rx;
        logic rx_full;
        logic rx_af;
        logic rx_empty;
        logic tx_full;
        logic tx_ae;
        logic tx_empty;
    } status_t;

    typedef enum logic [1:0] {
        IrqTxAe,
        IrqRxAf,
        IrqEndRx,
        IrqSticky
    } irq_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; push on full and pop on empty
// are ignored using the pre-edge full/empty values.
module sync_fifo #(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] wdata,
    output logic [LVL_W-1:0]      level,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_WIDTH-1:0] rdata
);

    logic [FIFO_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  push_ok, pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];

    // Storage is deliberately left out of reset and flush
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/apb_fifo_bridge.sv
// APB slave front end for a TX/RX FIFO pair with levels, thresholds, sticky flags and an
// RX transfer counter. Define APB_FIFO_IRQ_EN to add the IRQ register and irq output.
module apb_fifo_bridge
    import apb_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [31:0]           paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    input  logic [3:0]            pstrb,
    output logic                  pready,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    input  logic                  read_fifo_tx,
    output logic [FIFO_WIDTH-1:0] fifo_r_data_tx,
    output logic                  empty_tx,
    output logic                  almost_empty_tx,
    input  logic                  write_fifo_rx,
    input  logic [FIFO_WIDTH-1:0] fifo_w_data_rx,
    output logic                  full_rx,
    output logic                  almost_full_rx,
    output logic                  end_rx
`ifdef APB_FIFO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic                  access, wr, rd, in_range;
    logic [7:0]            hit;
    logic                  tx_push, tx_flush, tx_full, tx_empty;
    logic                  rx_pop, rx_flush, rx_full, rx_empty, rx_push_ok;
    logic                  ctrl_wr, sticky_clr;
    logic [LVL_W-1:0]      tx_level, rx_level;
    logic [FIFO_WIDTH-1:0] rx_head;
    logic                  tx_ovf_q, rx_ovf_q, rx_udf_q;
    logic [31:0]           rem_q;
    logic [15:0]           tx_ae_th_q, rx_af_th_q;
    status_t               status;
    logic [31:0]           status_word;
    logic                  unused_ok;

    assign unused_ok = ^{pstrb, paddr[1:0]};

    assign access   = psel & penable;
    assign wr       = access & pwrite;
    assign rd       = access & ~pwrite;
    assign in_range = (paddr[31:5] == BASE_ADDR[31:5]);
    assign hit      = in_range ? (8'b1 << paddr[4:2]) : 8'b0;
    assign pready   = access;

    assign tx_push    = wr & hit[RegTxData];
    assign rx_pop     = rd & hit[RegRxData];
    assign ctrl_wr    = wr & hit[RegCtrl];
    assign tx_flush   = ctrl_wr & pwdata[0];
    assign rx_flush   = ctrl_wr & pwdata[1];
    assign sticky_clr = ctrl_wr & pwdata[2];
    assign rx_push_ok = write_fifo_rx & ~rx_full & ~rx_flush;

    sync_fifo #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .DEPTH     (DEPTH)
    ) u_tx_fifo (
        .clk  (pclk),
        .rst  (preset),
        .push (tx_push),
        .pop  (read_fifo_tx),
        .flush(tx_flush),
        .wdata(pwdata[FIFO_WIDTH-1:0]),
        .level(tx_level),
        .full (tx_full),
        .empty(tx_empty),
        .rdata(fifo_r_data_tx)
    );

    sync_fifo #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .DEPTH     (DEPTH)
    ) u_rx_fifo (
        .clk  (pclk),
        .rst  (preset),
        .push (write_fifo_rx),
        .pop  (rx_pop),
        .flush(rx_flush),
        .wdata(fifo_w_data_rx),
        .level(rx_level),
        .full (rx_full),
        .empty(rx_empty),
        .rdata(rx_head)
    );

    assign empty_tx        = tx_empty;
    assign almost_empty_tx = 16'(tx_level) <= tx_ae_th_q;
    assign full_rx         = rx_full;
    assign almost_full_rx  = 16'(rx_level) >= rx_af_th_q;
    assign end_rx          = (rem_q == '0);

    always_comb begin
        status          = '0;
        status.tx_empty = tx_empty;
        status.tx_ae    = almost_empty_tx;
        status.tx_full  = tx_full;
        status.rx_empty = rx_empty;
        status.rx_af    = almost_full_rx;
        status.rx_full  = rx_full;
        status.end_rx   = end_rx;
        status.tx_ovf   = tx_ovf_q;
        status.rx_ovf   = rx_ovf_q;
        status.rx_udf   = rx_udf_q;
    end
    assign status_word = 32'(status);

    always_ff @(posedge pclk) begin
        if (preset) begin
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
            rem_q      <= '0;
            tx_ae_th_q <= 16'd1;
            rx_af_th_q <= 16'(DEPTH - 1);
        end else begin
            // A clear and a new event in the same cycle keep the new event
            tx_ovf_q <= (tx_ovf_q & ~sticky_clr) | (tx_push & tx_full);
            rx_ovf_q <= (rx_ovf_q & ~sticky_clr) | (write_fifo_rx & rx_full);
            rx_udf_q <= (rx_udf_q & ~sticky_clr) | (rx_pop & rx_empty);
            if (wr && hit[RegNReads]) begin
                rem_q <= pwdata;
            end else if (rx_push_ok && rem_q != '0) begin
                rem_q <= rem_q - 32'd1;
            end
            if (wr && hit[RegThresh]) begin
                tx_ae_th_q <= pwdata[15:0];
                rx_af_th_q <= pwdata[31:16];
            end
        end
    end

`ifdef APB_FIFO_IRQ_EN
    logic [3:0] irq_en_q;
    logic [3:0] irq_raw;
    logic       irq_q;

    always_comb begin
        irq_raw            = '0;
        irq_raw[IrqTxAe]   = status_word[StTxAe];
        irq_raw[IrqRxAf]   = status_word[StRxAf];
        irq_raw[IrqEndRx]  = status_word[StEndRx];
        irq_raw[IrqSticky] = |status_word[StRxUdf:StTxOvf];
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= |(irq_en_q & irq_raw);
            if (wr && hit[RegIrq]) irq_en_q <= pwdata[3:0];
        end
    end
    assign irq = irq_q;
`endif

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            if (!in_range) begin
                pslverr = 1'b1;
            end else begin
                case (paddr[4:2])
                    RegTxData: pslverr = pwrite & tx_full;
                    RegRxData: begin
                        if (pwrite || rx_empty) pslverr = 1'b1;
                        else                    prdata  = 32'(rx_head);
                    end
                    RegStatus: begin
                        if (pwrite) pslverr = 1'b1;
                        else        prdata  = status_word;
                    end
                    RegLevel: begin
                        if (pwrite) pslverr = 1'b1;
                        else        prdata  = {16'(rx_level), 16'(tx_level)};
                    end
                    RegCtrl:   prdata = '0;
                    RegNReads: if (!pwrite) prdata = rem_q;
                    RegThresh: if (!pwrite) prdata = {rx_af_th_q, tx_ae_th_q};
`ifdef APB_FIFO_IRQ_EN
                    RegIrq:    if (!pwrite) prdata = {12'b0, irq_raw, 12'b0, irq_en_q};
`endif
                    default:   pslverr = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Directed bench for apb_fifo_bridge with a queue-based reference model checked every cycle.
module tb_apb_fifo_bridge;

    localparam logic [31:0] BASE  = 32'h4000_0100;
    localparam int          DEPTH = 16;
    localparam int          FW    = 32;

    localparam logic [31:0] O_TX = 32'h00, O_RX = 32'h04, O_ST = 32'h08, O_LV = 32'h0C;
    localparam logic [31:0] O_CT = 32'h10, O_NR = 32'h14, O_TH = 32'h18, O_IQ = 32'h1C;

    logic          pclk, preset;
    logic [31:0]   paddr, pwdata, prdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [3:0]    pstrb;
    logic          read_fifo_tx, write_fifo_rx;
    logic [FW-1:0] fifo_r_data_tx, fifo_w_data_rx;
    logic          empty_tx, almost_empty_tx, full_rx, almost_full_rx, end_rx;
`ifdef APB_FIFO_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;

    apb_fifo_bridge #(
        .BASE_ADDR (BASE),
        .FIFO_WIDTH(FW),
        .DEPTH     (DEPTH)
    ) dut (
        .pclk           (pclk),
        .preset         (preset),
        .paddr          (paddr),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .pwdata         (pwdata),
        .pstrb          (pstrb),
        .pready         (pready),
        .prdata         (prdata),
        .pslverr        (pslverr),
        .read_fifo_tx   (read_fifo_tx),
        .fifo_r_data_tx (fifo_r_data_tx),
        .empty_tx       (empty_tx),
        .almost_empty_tx(almost_empty_tx),
        .write_fifo_rx  (write_fifo_rx),
        .fifo_w_data_rx (fifo_w_data_rx),
        .full_rx        (full_rx),
        .almost_full_rx (almost_full_rx),
        .end_rx         (end_rx)
`ifdef APB_FIFO_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic        m_tx_ovf, m_rx_ovf, m_rx_udf, m_irq;
    logic [31:0] m_rem;
    logic [15:0] m_ae_th, m_af_th;
    logic [3:0]  m_en;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = '0;
        s[0] = (tx_q.size() == 0);
        s[1] = (tx_q.size() <= int'(m_ae_th));
        s[2] = (tx_q.size() == DEPTH);
        s[3] = (rx_q.size() == 0);
        s[4] = (rx_q.size() >= int'(m_af_th));
        s[5] = (rx_q.size() == DEPTH);
        s[6] = (m_rem == 0);
        s[7] = m_tx_ovf;
        s[8] = m_rx_ovf;
        s[9] = m_rx_udf;
        return s;
    endfunction

    function automatic logic [3:0] m_raw();
        logic [31:0] s;
        s = m_status();
        return {m_tx_ovf | m_rx_ovf | m_rx_udf, s[6], s[4], s[1]};
    endfunction

    function automatic void exp_apb(output logic [31:0] d, output logic e);
        d = '0;
        e = 1'b0;
        if (!(psel && penable)) return;
        if (paddr[31:5] != BASE[31:5]) begin
            e = 1'b1;
            return;
        end
        case (paddr[4:2])
            3'd0: if (pwrite) e = (tx_q.size() == DEPTH);
            3'd1: begin
                if (pwrite || rx_q.size() == 0) e = 1'b1;
                else d = rx_q[0];
            end
            3'd2: if (pwrite) e = 1'b1; else d = m_status();
            3'd3: if (pwrite) e = 1'b1; else d = {16'(rx_q.size()), 16'(tx_q.size())};
            3'd4: ;
            3'd5: if (!pwrite) d = m_rem;
            3'd6: if (!pwrite) d = {m_af_th, m_ae_th};
`ifdef APB_FIFO_IRQ_EN
            3'd7: if (!pwrite) d = {12'b0, m_raw(), 12'b0, m_en};
`else
            3'd7: e = 1'b1;
`endif
            default: e = 1'b1;
        endcase
    endfunction

    always @(posedge pclk) begin : model_upd
        logic       acc, inr, txf, txe, rxf, rxe, flt, flr, clr;
        logic       tx_push, rx_pop, rx_push_ok;
        logic [2:0] off;
        logic [3:0] raw;
        if (preset) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_ovf = 0; m_rx_ovf = 0; m_rx_udf = 0; m_irq = 0;
            m_rem = 0; m_ae_th = 16'd1; m_af_th = 16'(DEPTH - 1); m_en = 0;
        end else begin
            acc = psel && penable;
            inr = (paddr[31:5] == BASE[31:5]);
            off = paddr[4:2];
            txf = (tx_q.size() == DEPTH); txe = (tx_q.size() == 0);
            rxf = (rx_q.size() == DEPTH); rxe = (rx_q.size() == 0);
            raw = m_raw();
            m_irq = |(m_en & raw);
            tx_push = acc && pwrite && inr && off == 3'd0;
            rx_pop  = acc && !pwrite && inr && off == 3'd1;
            flt = acc && pwrite && inr && off == 3'd4 && pwdata[0];
            flr = acc && pwrite && inr && off == 3'd4 && pwdata[1];
            clr = acc && pwrite && inr && off == 3'd4 && pwdata[2];
            rx_push_ok = write_fifo_rx && !rxf && !flr;
            if (flt) tx_q.delete();
            else begin
                if (read_fifo_tx && !txe) void'(tx_q.pop_front());
                if (tx_push && !txf) tx_q.push_back(pwdata);
            end
            if (flr) rx_q.delete();
            else begin
                if (rx_pop && !rxe) void'(rx_q.pop_front());
                if (rx_push_ok) rx_q.push_back(fifo_w_data_rx);
            end
            if (clr) begin m_tx_ovf = 0; m_rx_ovf = 0; m_rx_udf = 0; end
            if (tx_push && txf) m_tx_ovf = 1;
            if (write_fifo_rx && rxf) m_rx_ovf = 1;
            if (rx_pop && rxe) m_rx_udf = 1;
            if (acc && pwrite && inr && off == 3'd5) m_rem = pwdata;
            else if (rx_push_ok && m_rem != 0) m_rem = m_rem - 1;
            if (acc && pwrite && inr && off == 3'd6) begin
                m_ae_th = pwdata[15:0];
                m_af_th = pwdata[31:16];
            end
`ifdef APB_FIFO_IRQ_EN
            if (acc && pwrite && inr && off == 3'd7) m_en = pwdata[3:0];
`endif
        end
    end

    always @(negedge pclk) begin : compare
        logic [31:0] ed, st;
        logic        ee;
        if (!preset) begin
            st = m_status();
            exp_apb(ed, ee);
            chk("empty_tx", 32'(empty_tx), 32'(st[0]));
            chk("almost_empty_tx", 32'(almost_empty_tx), 32'(st[1]));
            chk("full_rx", 32'(full_rx), 32'(st[5]));
            chk("almost_full_rx", 32'(almost_full_rx), 32'(st[4]));
            chk("end_rx", 32'(end_rx), 32'(st[6]));
            if (tx_q.size() != 0) chk("fifo_r_data_tx", fifo_r_data_tx, tx_q[0]);
            chk("pready", 32'(pready), 32'(psel && penable));
            chk("pslverr", 32'(pslverr), 32'(ee));
            chk("prdata", prdata, ed);
`ifdef APB_FIFO_IRQ_EN
            chk("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apb(input logic w, input logic [31:0] off, input logic [31:0] d,
                       input logic pop, output logic [31:0] rdat, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = BASE + off; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        read_fifo_tx = pop;
        @(negedge pclk);
        rdat = prdata;
        err  = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; read_fifo_tx = 1'b0;
    endtask

    task automatic core_push(input logic [31:0] d);
        @(posedge pclk); #1;
        write_fifo_rx = 1'b1; fifo_w_data_rx = d;
        @(posedge pclk); #1;
        write_fifo_rx = 1'b0;
    endtask

    task automatic core_pop();
        @(posedge pclk); #1;
        read_fifo_tx = 1'b1;
        @(posedge pclk); #1;
        read_fifo_tx = 1'b0;
    endtask

    logic [31:0] rd_v;
    logic        er;

    initial begin
        preset = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        pstrb = 4'hF; read_fifo_tx = 0; write_fifo_rx = 0; fifo_w_data_rx = 0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        apb(0, O_ST, 0, 0, rd_v, er); chk("reset STATUS", rd_v, 32'h0000_004B);
        apb(0, O_LV, 0, 0, rd_v, er); chk("reset LEVEL", rd_v, 32'h0);

        for (int i = 1; i <= 17; i++) begin
            apb(1, O_TX, 32'(i), 0, rd_v, er);
            chk("tx write err", 32'(er), (i == 17) ? 32'd1 : 32'd0);
        end
        apb(0, O_ST, 0, 0, rd_v, er); chk("STATUS tx full+ovf", rd_v, 32'h0000_00CC);
        apb(0, O_LV, 0, 0, rd_v, er); chk("LEVEL tx 16", rd_v, 32'h0000_0010);
        for (int i = 1; i <= 16; i++) begin
            #1 chk("tx head order", fifo_r_data_tx, 32'(i));
            core_pop();
        end
        chk("empty_tx after drain", 32'(empty_tx), 32'd1);

        apb(1, O_CT, 32'h4, 0, rd_v, er);
        apb(1, O_NR, 32'd3, 0, rd_v, er);
        chk("end_rx after N_READS", 32'(end_rx), 32'd0);
        core_push(32'hA1);
        core_push(32'hA2);
        chk("end_rx mid", 32'(end_rx), 32'd0);
        core_push(32'hA3);
        chk("end_rx after 3rd push", 32'(end_rx), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apb(0, O_RX, 0, 0, rd_v, er);
            chk("rx read data", rd_v, 32'hA1 + 32'(i));
            chk("rx read err", 32'(er), 32'd0);
        end
        apb(0, O_RX, 0, 0, rd_v, er);
        chk("rx underflow err", 32'(er), 32'd1);
        chk("rx underflow data", rd_v, 32'd0);
        apb(0, O_ST, 0, 0, rd_v, er); chk("STATUS rx_udf", rd_v & 32'h200, 32'h200);

        apb(1, O_TH, {16'd4, 16'd1}, 0, rd_v, er);
        for (int i = 0; i < 4; i++) begin
            core_push(32'hB0 + 32'(i));
            chk("almost_full_rx", 32'(almost_full_rx), (i == 3) ? 32'd1 : 32'd0);
        end
        apb(0, O_LV, 0, 0, rd_v, er); chk("LEVEL rx 4", rd_v, 32'h0004_0000);

        apb(0, 32'h20, 0, 0, rd_v, er); chk("above range err", 32'(er), 32'd1);
        apb(0, 32'hFFFF_FFFC, 0, 0, rd_v, er); chk("below range err", 32'(er), 32'd1);
        apb(1, O_ST, 32'h1, 0, rd_v, er); chk("STATUS write err", 32'(er), 32'd1);
        apb(0, O_TX, 0, 0, rd_v, er); chk("TX_DATA read", {rd_v[30:0], er}, 32'd0);
        apb(0, O_TH, 0, 0, rd_v, er); chk("THRESH read", rd_v, 32'h0004_0001);
`ifndef APB_FIFO_IRQ_EN
        apb(0, O_IQ, 0, 0, rd_v, er); chk("IRQ reg absent err", 32'(er), 32'd1);
`endif

        for (int i = 0; i < 5; i++) apb(1, O_TX, 32'hC0 + 32'(i), 0, rd_v, er);
        apb(1, O_CT, 32'h1, 1, rd_v, er);
        chk("empty_tx after flush", 32'(empty_tx), 32'd1);
        apb(0, O_LV, 0, 0, rd_v, er); chk("LEVEL after tx flush", rd_v, 32'h0004_0000);

        for (int i = 0; i < 13; i++) core_push(32'hD0 + 32'(i));
        apb(0, O_ST, 0, 0, rd_v, er); chk("STATUS rx full+ovf", rd_v, 32'h0000_0373);
        apb(0, O_NR, 0, 0, rd_v, er); chk("N_READS at zero", rd_v, 32'd0);
        apb(1, O_CT, 32'h2, 0, rd_v, er);
        apb(0, O_LV, 0, 0, rd_v, er); chk("LEVEL after rx flush", rd_v, 32'd0);
        apb(1, O_CT, 32'h4, 0, rd_v, er);
        apb(0, O_ST, 0, 0, rd_v, er); chk("STATUS after clear", rd_v, 32'h0000_004B);

        for (int i = 0; i < 3; i++) apb(1, O_TX, 32'hE0 + 32'(i), 0, rd_v, er);
        apb(1, O_NR, 32'd9, 0, rd_v, er);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = BASE + O_TX; pwdata = 32'hEE;
        write_fifo_rx = 1; fifo_w_data_rx = 32'h55;
        @(posedge pclk); #1;
        penable = 1; preset = 1;
        @(posedge pclk); #1;
        psel = 0; penable = 0; pwrite = 0; write_fifo_rx = 0; preset = 0;
        apb(0, O_ST, 0, 0, rd_v, er); chk("STATUS after mid reset", rd_v, 32'h0000_004B);
        apb(0, O_LV, 0, 0, rd_v, er); chk("LEVEL after mid reset", rd_v, 32'd0);

`ifdef APB_FIFO_IRQ_EN
        apb(1, O_IQ, 32'h4, 0, rd_v, er);
        apb(1, O_NR, 32'd1, 0, rd_v, er);
        repeat (2) @(posedge pclk);
        #1 chk("irq low while counting", 32'(irq), 32'd0);
        core_push(32'h77);
        chk("irq not yet", 32'(irq), 32'd0);
        @(posedge pclk); #1;
        chk("irq after end_rx", 32'(irq), 32'd1);
        apb(0, O_IQ, 0, 0, rd_v, er); chk("IRQ reg read", rd_v, 32'h0005_0004);
        apb(1, O_IQ, 32'h0, 0, rd_v, er);
        @(posedge pclk); #1;
        chk("irq after disable", 32'(irq), 32'd0);
`endif

        repeat (2) @(posedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
